// File: rtl/note_table_arbiter.sv
// Shares one synchronous note -> phase-delta ROM between NUM_REQ sequencers via a grant/read pipeline.
// Build option NOTE_ARB_FIXED_PRIO_EN: lowest eligible index wins instead of round-robin.
module note_table_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned NOTE_W          = 6,
  parameter int unsigned DATA_W          = 32,
  parameter string       NOTE_TABLE_FILE = ""
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*NOTE_W-1:0] i_req_note,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_valid,
  output logic [DATA_W-1:0]         o_phase_delta,
  output logic                      o_busy
);

  localparam int unsigned DEPTH = 1 << NOTE_W;
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef logic [DEPTH-1:0][DATA_W-1:0] rom_t;

  // Table image; all entries read as zero unless preloaded.
  rom_t rom = '0;

  logic [NUM_REQ-1:0] elig_c;
  logic [IDX_W-1:0]   win_c;
  logic               found_c;
  logic [NOTE_W-1:0]  note_c;
  logic [NOTE_W-1:0]  addr;

  // A channel already in the grant or read stage may not start another lookup.
  assign elig_c = i_req & ~o_grant & ~o_valid;

`ifdef NOTE_ARB_FIXED_PRIO_EN
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_c && elig_c[i]) begin
        win_c   = IDX_W'(i);
        found_c = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;
  int unsigned      cand_c;

  // Search ptr+1, ptr+2, ... wrapping at NUM_REQ; ptr is the last winner.
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    cand_c  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_c = 32'(ptr) + k;
      if (cand_c >= NUM_REQ) cand_c = cand_c - NUM_REQ;
      if (!found_c && elig_c[IDX_W'(cand_c)]) begin
        win_c   = IDX_W'(cand_c);
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (found_c) begin
      ptr <= win_c;
    end
  end
`endif

  always_comb begin
    note_c = '0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      if (win_c == IDX_W'(n)) note_c = i_req_note[n*NOTE_W +: NOTE_W];
    end
  end

  // Stage G captures winner and note; stage R reads the ROM for last cycle's winner.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_grant       <= '0;
      o_valid       <= '0;
      o_phase_delta <= '0;
      o_busy        <= 1'b0;
      addr          <= '0;
    end else begin
      o_grant <= found_c ? (NUM_REQ'(1) << win_c) : '0;
      o_valid <= o_grant;
      o_busy  <= found_c | (|o_grant);
      if (found_c) addr <= note_c;
      if (|o_grant) o_phase_delta <= rom[addr];
    end
  end

endmodule

// File: tb/tb_note_table_arbiter.sv
// Bench for note_table_arbiter: vector table, directed corner sequences, random vs timestamp model.
module tb_note_table_arbiter;

  localparam int NREQ = 4;
  localparam int NW   = 6;
  localparam int DW   = 32;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*NW-1:0]   notes;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      valid;
  logic [DW-1:0]        pd;
  logic                 busy;

  int checks;
  int failures;
  logic [DW-1:0] rom_model [64];

  note_table_arbiter #(
    .NUM_REQ(NREQ), .NOTE_W(NW), .DATA_W(DW), .NOTE_TABLE_FILE("")
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_req_note(notes),
    .o_grant(grant), .o_valid(valid), .o_phase_delta(pd), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*NW-1:0] notes;
    logic [NREQ-1:0]   g;
    logic [NREQ-1:0]   v;
    logic [DW-1:0]     pd;
    logic              b;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*NW-1:0] nt,
                         input logic [NREQ-1:0] g, input logic [NREQ-1:0] v,
                         input logic [DW-1:0] p, input logic b);
    vec_t x;
    x.rst = r; x.req = rq; x.notes = nt; x.g = g; x.v = v; x.pd = p; x.b = b;
    vecs.push_back(x);
  endtask

  function automatic logic [NREQ*NW-1:0] pack_notes(input logic [NW-1:0] n0, input logic [NW-1:0] n1,
                                                   input logic [NW-1:0] n2, input logic [NW-1:0] n3);
    return {n3, n2, n1, n0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [NREQ-1:0] eg, input logic [NREQ-1:0] ev,
                         input logic [DW-1:0] epd, input logic eb);
    chk({nm, " grant"}, 64'(grant), 64'(eg));
    chk({nm, " valid"}, 64'(valid), 64'(ev));
    chk({nm, " phase_delta"}, 64'(pd), 64'(epd));
    chk({nm, " busy"}, 64'(busy), 64'(eb));
  endtask

  // Inputs are stable across the edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: a channel is free 3 edges after its last grant; winner by rule, not by masks.
  int              m_edge;
  int              m_ptr;
  int              m_prev_w;
  int              m_last_g [NREQ];
  logic [NW-1:0]   m_prev_note;
  logic [DW-1:0]   m_pd;
  logic [NREQ-1:0] e_grant;
  logic [NREQ-1:0] e_valid;
  logic [DW-1:0]   e_pd;
  logic            e_busy;

  task automatic model_edge(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*NW-1:0] nt);
    int w;
    int c;
    if (r) begin
      for (int n = 0; n < NREQ; n++) m_last_g[n] = -100;
      m_ptr    = NREQ - 1;
      m_prev_w = -1;
      m_pd     = '0;
      e_grant  = '0;
      e_valid  = '0;
      e_busy   = 1'b0;
    end else begin
      e_valid = '0;
      if (m_prev_w >= 0) begin
        e_valid = NREQ'(1) << m_prev_w;
        m_pd    = rom_model[m_prev_note];
      end
      w = -1;
`ifdef NOTE_ARB_FIXED_PRIO_EN
      for (int n = 0; n < NREQ; n++)
        if (w < 0 && rq[n] && (m_edge - m_last_g[n] > 2)) w = n;
`else
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (w < 0 && rq[c] && (m_edge - m_last_g[c] > 2)) w = c;
      end
`endif
      e_grant = '0;
      if (w >= 0) begin
        e_grant     = NREQ'(1) << w;
        m_last_g[w] = m_edge;
        m_ptr       = w;
        m_prev_note = nt[w*NW +: NW];
      end
      m_prev_w = w;
      e_busy   = (w >= 0) || (e_valid != '0);
    end
    e_pd = m_pd;
    m_edge++;
  endtask

  initial begin
    logic [NREQ*NW-1:0] n4;
    vec_t               v;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    notes    = '0;
    m_edge   = 0;
    for (int i = 0; i < 64; i++)
      rom_model[i] = (32'(i) * 32'h0101_0103) ^ 32'h5A00_0000 ^ (32'(i) << 20);
    rom_model[5] = 32'h0134AB02;
    #1;
    for (int i = 0; i < 64; i++) dut.rom[i] = rom_model[i];

    // Reset state, single lookup, then all four requesters dropping on their valid.
    add_vec(1, 4'b0000, '0, 4'b0000, 4'b0000, '0, 0);
    add_vec(1, 4'b0000, '0, 4'b0000, 4'b0000, '0, 0);
    n4 = pack_notes(6'd0, 6'd5, 6'd0, 6'd0);
    add_vec(0, 4'b0010, n4, 4'b0010, 4'b0000, '0, 1);
    add_vec(0, 4'b0000, n4, 4'b0000, 4'b0010, rom_model[5], 1);
    add_vec(0, 4'b0000, n4, 4'b0000, 4'b0000, rom_model[5], 0);
    add_vec(1, 4'b0000, n4, 4'b0000, 4'b0000, '0, 0);
    n4 = pack_notes(6'd10, 6'd11, 6'd12, 6'd13);
    add_vec(0, 4'b1111, n4, 4'b0001, 4'b0000, '0, 1);
    add_vec(0, 4'b1111, n4, 4'b0010, 4'b0001, rom_model[10], 1);
    add_vec(0, 4'b1110, n4, 4'b0100, 4'b0010, rom_model[11], 1);
    add_vec(0, 4'b1100, n4, 4'b1000, 4'b0100, rom_model[12], 1);
    add_vec(0, 4'b1000, n4, 4'b0000, 4'b1000, rom_model[13], 1);
    add_vec(0, 4'b0000, n4, 4'b0000, 4'b0000, rom_model[13], 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v     = vecs[i];
      rst   = v.rst;
      req   = v.req;
      notes = v.notes;
      tick();
      chk_out($sformatf("vec%0d", i), v.g, v.v, v.pd, v.b);
    end

    // Reset mid-lookup discards the in-flight ch2 lookup; ch0 then wins first.
    do_reset();
    req   = 4'b0100;
    notes = pack_notes(6'd1, 6'd0, 6'd7, 6'd0);
    tick();
    chk("rstmid grant", 64'(grant), 64'(4'b0100));
    rst = 1'b1;
    req = 4'b0000;
    tick();
    chk_out("rstmid reset", 4'b0000, 4'b0000, '0, 1'b0);
    rst = 1'b0;
    req = 4'b0101;
    tick();
    chk_out("rstmid first", 4'b0001, 4'b0000, '0, 1'b1);
    tick();
    chk_out("rstmid second", 4'b0100, 4'b0001, rom_model[1], 1'b1);
    req = 4'b0000;
    tick();
    tick();

    // Note captured at grant; a later change must not affect the lookup.
    do_reset();
    req   = 4'b0100;
    notes = pack_notes(6'd0, 6'd0, 6'd3, 6'd0);
    tick();
    chk("notechg grant", 64'(grant), 64'(4'b0100));
    notes = pack_notes(6'd0, 6'd0, 6'd9, 6'd0);
    tick();
    chk("notechg valid", 64'(valid), 64'(4'b0100));
    chk("notechg data", 64'(pd), 64'(rom_model[3]));
    req = 4'b0000;
    tick();
    tick();

    // Held ch0+ch3, then ch0+ch1: a 3-edge cycle of ch0, other, idle.
    do_reset();
    req   = 4'b1001;
    notes = pack_notes(6'd2, 6'd0, 6'd0, 6'd4);
    for (int j = 0; j < 30; j++) begin
      tick();
      chk($sformatf("fair03 grant%0d", j), 64'(grant),
          64'((j % 3 == 0) ? 4'b0001 : (j % 3 == 1) ? 4'b1000 : 4'b0000));
      chk($sformatf("fair03 valid%0d", j), 64'(valid),
          64'((j % 3 == 1) ? 4'b0001 : (j % 3 == 2) ? 4'b1000 : 4'b0000));
    end
    do_reset();
    req = 4'b0011;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk($sformatf("prio01 grant%0d", j), 64'(grant),
          64'((j % 3 == 0) ? 4'b0001 : (j % 3 == 1) ? 4'b0010 : 4'b0000));
    end

    // Random traffic with occasional resets against the model.
    for (int c = 0; c < 600; c++) begin
      rst   = (c == 0) || ($urandom_range(0, 59) == 0);
      req   = NREQ'($urandom);
      notes = (NREQ*NW)'($urandom);
      tick();
      model_edge(rst, req, notes);
      chk_out($sformatf("rnd%0d", c), e_grant, e_valid, e_pd, e_busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
